// File: rtl/color_pkg.sv
// Shared constants, fade-mode encoding and packing helper for the colour register bank.
// Exports: DEFAULT_CHANNELS, DEFAULT_WIDTH, fade_mode_e, ch_lsb().
package color_pkg;

    localparam int unsigned DEFAULT_CHANNELS = 3;
    localparam int unsigned DEFAULT_WIDTH    = 8;

    typedef enum logic {
        MODE_IMMEDIATE = 1'b0,
        MODE_RAMP      = 1'b1
    } fade_mode_e;

    // LSB position of channel `ch` inside a packed CHANNELS*WIDTH vector.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/color_fade_regbank_if.sv
// Host-side bus of the colour register bank.
// master: drives ch_in/write_enable/commit/fade_mode, observes ch_out/busy/done.
// slave : the register bank itself.
interface color_fade_regbank_if
    import color_pkg::*;
#(
    parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
    parameter int unsigned WIDTH    = DEFAULT_WIDTH
);
    logic [CHANNELS*WIDTH-1:0] ch_in;
    logic [CHANNELS-1:0]       write_enable;
    logic                      commit;
    logic                      fade_mode;
    logic [CHANNELS*WIDTH-1:0] ch_out;
    logic                      busy;
    logic                      done;

    modport master (
        output ch_in, write_enable, commit, fade_mode,
        input  ch_out, busy, done
    );

    modport slave (
        input  ch_in, write_enable, commit, fade_mode,
        output ch_out, busy, done
    );

endinterface

// File: rtl/fade_channel.sv
// One colour channel: shadow, target and output registers plus the clamped step toward target.
// Ports: clk, rst (sync, active-high); din/we shadow write; commit/immediate load target
// (and output when immediate); step_en advances out by min(STEP, |target-out|);
// out registered level; at_target = out==target now; at_target_next_c = same after this edge.
module fade_channel
    import color_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             we,
    input  logic             commit,
    input  logic             immediate,
    input  logic             step_en,
    output logic [WIDTH-1:0] out,
    output logic             at_target,
    output logic             at_target_next_c
);
    localparam int unsigned DW = WIDTH + 1;
    localparam logic [DW-1:0] STEP_W = DW'(STEP);

    logic [WIDTH-1:0] shadow_q, target_q, out_q;
    logic [WIDTH-1:0] shadow_d, target_d, out_d;
    logic [WIDTH-1:0] commit_val;
    logic [DW-1:0]    diff, delta;
    logic             up;

    // Next-state: a same-edge write bypasses the shadow into the target.
    always_comb begin
        commit_val = we ? din : shadow_q;
        shadow_d   = commit_val;
        target_d   = target_q;
        out_d      = out_q;
        up         = target_q > out_q;
        diff       = up ? ({1'b0, target_q} - {1'b0, out_q})
                        : ({1'b0, out_q} - {1'b0, target_q});
        delta      = (diff < STEP_W) ? diff : STEP_W;

        if (commit) begin
            target_d = commit_val;
            if (immediate) begin
                out_d = commit_val;
            end
        end else if (step_en) begin
            // delta never exceeds the distance, so the result stays in range.
            out_d = up ? WIDTH'({1'b0, out_q} + delta) : WIDTH'({1'b0, out_q} - delta);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            target_q <= '0;
            out_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            target_q <= target_d;
            out_q    <= out_d;
        end
    end

    assign out              = out_q;
    assign at_target        = (out_q == target_q);
    assign at_target_next_c = (out_d == target_d);

endmodule

// File: rtl/color_fade_regbank.sv
// Double-buffered colour register bank with immediate or ramped transitions.
// Ports: clk, rst (sync, active-high), bus (slave modport): ch_in/write_enable shadow writes,
// commit/fade_mode start a transition, ch_out registered levels, busy (combinational,
// any channel off target), done (registered one-cycle completion pulse).
module color_fade_regbank
    import color_pkg::*;
#(
    parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned STEP     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    color_fade_regbank_if.slave  bus
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]             presc_q, presc_d;
    fade_mode_e                mode_q, mode_d;
    logic                      done_q, done_d;
    logic [CHANNELS-1:0]       at_target, at_target_next;
    logic [CHANNELS*WIDTH-1:0] ch_out_w;
    logic                      busy_c, wrap_c, step_en_c, immediate_c;

    assign immediate_c = (fade_mode_e'(bus.fade_mode) == MODE_IMMEDIATE);
    assign busy_c      = ~&at_target;
    assign wrap_c      = (presc_q == PRESC_LAST);
    assign step_en_c   = busy_c && (mode_q == MODE_RAMP) && wrap_c && !bus.commit;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        fade_channel #(
            .WIDTH (WIDTH),
            .STEP  (STEP)
        ) u_ch (
            .clk              (clk),
            .rst              (rst),
            .din              (bus.ch_in[ch_lsb(i, WIDTH) +: WIDTH]),
            .we               (bus.write_enable[i]),
            .commit           (bus.commit),
            .immediate        (immediate_c),
            .step_en          (step_en_c),
            .out              (ch_out_w[ch_lsb(i, WIDTH) +: WIDTH]),
            .at_target        (at_target[i]),
            .at_target_next_c (at_target_next[i])
        );
    end

    // Prescaler/mode next-state; done fires when this edge leaves every channel on target,
    // either from a commit or from the final step of an active transition. A commit that
    // replaces a running ramp only reports completion of the new transition.
    always_comb begin
        presc_d = presc_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (bus.commit) begin
            presc_d = '0;
            mode_d  = fade_mode_e'(bus.fade_mode);
            done_d  = &at_target_next;
        end else if (busy_c) begin
            presc_d = wrap_c ? '0 : presc_q + PW'(1);
            done_d  = &at_target_next;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            mode_q  <= MODE_IMMEDIATE;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign bus.ch_out = ch_out_w;
    assign bus.busy   = busy_c;
    assign bus.done   = done_q;

endmodule
